lc3_mem_responder: RTL and testbench
====================================

# lc3_mem_responder

Memory-side responder for the LC-3 datapath's MAR/MDR memory port. Accepts one read or write request at a time over a four-phase request/ready handshake and services it from external asynchronous SRAM with a configurable number of wait states. It returns read data on `MDR_In` and optionally decodes a memory-mapped switch/hex-display register at address 0xFFFF. Sits between the datapath/control FSM and the board SRAM pins.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: extra SRAM access cycles per transaction; legal range 0–15.

Ports (the single clock is `Clk`; reset is synchronous and active-low, `Reset_al`):
- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Reset_al`  in  1  synchronous, active-low reset.
- `Mem_CE`  in  1  request from the control FSM; held high until `R` is seen.
- `Mem_WE`  in  1  1 = write, 0 = read; sampled with the request.
- `MAR`  in  16  address.
- `MDR`  in  16  write data.
- `MDR_In`  out  16  registered read data; valid while `R`=1.
- `R`  out  1  registered ready/acknowledge.
- `SRAM_ADDR`  out  20  SRAM address, equal to {4'b0, latched MAR}.
- `Data_to_SRAM`  out  16  latched write data.
- `Data_from_SRAM`  in  16  SRAM read data.
- `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_WE_N`  out  1 each  active-low SRAM strobes.
- `Data_SW`  in  16  board switches, used for the MMIO read.
- `HEX_Out`  out  16  MMIO hex-display register.

## Operation
- FSM states: IDLE, ACCESS, MMIO, DONE. A 4-bit down-counter `cnt` runs in ACCESS.
- **IDLE**, on an edge with `Mem_CE`=1:
  - Latch `MAR`, `MDR` and `Mem_WE` into internal registers.
  - If the address is 0xFFFF and MMIO is compiled in, go to MMIO.
  - Otherwise go to ACCESS with `cnt`=`WAIT_CYCLES`.
- **ACCESS**:
  - `SRAM_CE_N`=0.
  - Read: `SRAM_OE_N`=0, `SRAM_WE_N`=1.
  - Write: `SRAM_WE_N`=0, `SRAM_OE_N`=1.
  - Edge with `cnt`≠0: decrement `cnt`.
  - Edge with `cnt`=0: on a read, `MDR_In`←`Data_from_SRAM`; set `R`←1 and go to DONE.
- **MMIO**, one edge:
  - Read: `MDR_In`←`Data_SW`.
  - Write: `HEX_Out`←latched `MDR`.
  - Set `R`←1 and go to DONE. SRAM strobes stay deasserted.
- **DONE**:
  - Strobes are deasserted and `R` holds at 1.
  - Edge with `Mem_CE`=0: `R`←0 and go to IDLE.
  - Edge with `Mem_CE`=1: stay in DONE. No new request is accepted until `Mem_CE` has been seen low.
- `Mem_CE` falling during ACCESS or MMIO does not abort the transaction. It completes normally, `R` pulses for exactly one cycle, and the FSM then returns to IDLE.
- `MAR`, `MDR` and `Mem_WE` changes after the request edge are ignored.
- On a write, `MDR_In` keeps its previous value.
- Outside ACCESS, all three SRAM strobes are 1.
- Reset values (whenever `Reset_al`=0 at an edge, including mid-transaction):
  - FSM state: IDLE.
  - Outputs: `R`=0, `MDR_In`=0, `HEX_Out`=0, strobes=1, `SRAM_ADDR`=0, `Data_to_SRAM`=0.
  - Internal: `cnt`=0.

## Timing
- Request sampled at edge E0.
- SRAM path: `R` rises after edge E0+`WAIT_CYCLES`+1. Strobes are active for `WAIT_CYCLES`+1 cycles.
  - Default: `R` rises after E0+3.
  - `WAIT_CYCLES`=0: after E0+1.
- MMIO path: `R` rises after E0+1.
- `R` falls one edge after `Mem_CE` is sampled low.
- Minimum request-to-request spacing is latency + 2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `LC3_MEM_MMIO_EN` defined:
  - Address 0xFFFF is decoded as MMIO: reads return `Data_SW` and writes load `HEX_Out`.
  - The SRAM is never touched at 0xFFFF.
- `LC3_MEM_MMIO_EN` undefined:
  - MMIO state and decode are removed, and 0xFFFF is an ordinary SRAM address.
  - `HEX_Out` is tied to 0 and `Data_SW` is unused.

## Test plan
- **Reset:** `Reset_al`=0 for 2 cycles -> `R`=0, `MDR_In`=0, `HEX_Out`=0, all strobes 1.
- **SRAM read, `WAIT_CYCLES`=2:** `Data_from_SRAM`=0x1234, request read at `MAR`=0x3000 -> `SRAM_ADDR`=0x03000, `OE_N`/`CE_N` low for 3 cycles; `R`=1 with `MDR_In`=0x1234 after E0+3; `R` drops one edge after `Mem_CE`=0.
- **SRAM write:** `MAR`=0x0005, `MDR`=0xBEEF -> `WE_N` low for 3 cycles, `Data_to_SRAM`=0xBEEF; `MDR_In` unchanged.
- **MMIO (macro defined):**
  - Write 0x00A5 to 0xFFFF -> `HEX_Out`=0x00A5 after E0+1, with no strobes.
  - With `Data_SW`=0x0F0F, read 0xFFFF -> `MDR_In`=0x0F0F.
- **Held request and early drop:**
  - `Mem_CE` held high 5 cycles past `R` -> exactly one transaction, `R` stays 1.
  - `Mem_CE` dropped at E0+1 -> transaction completes and `R` pulses for one cycle.
- **Reset during ACCESS** (at E0+1) -> next edge: IDLE, strobes 1, `R`=0; a subsequent read completes normally.

Source files
------------

// File: rtl/lc3_mem_responder.sv
// LC-3 MAR/MDR memory responder: one request at a time, serviced from async SRAM or the 0xFFFF switch/hex register.
// Latency: R rises WAIT_CYCLES+1 edges after the request edge (SRAM), or 1 edge after it (MMIO).
// Backpressure: four-phase Mem_CE/R handshake; R holds until Mem_CE is seen low, and no new request is taken before that.
// Optional feature macro: LC3_MEM_MMIO_EN (decodes 0xFFFF as switches/hex display; undefined => plain SRAM address, HEX_Out = 0).
module lc3_mem_responder #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        Clk,
   input  logic        Reset_al,
   input  logic        Mem_CE,
   input  logic        Mem_WE,
   input  logic [15:0] MAR,
   input  logic [15:0] MDR,
   output logic [15:0] MDR_In,
   output logic        R,
   output logic [19:0] SRAM_ADDR,
   output logic [15:0] Data_to_SRAM,
   input  logic [15:0] Data_from_SRAM,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N,
   input  logic [15:0] Data_SW,
   output logic [15:0] HEX_Out
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
`ifdef LC3_MEM_MMIO_EN
   localparam logic [1:0] S_MMIO   = 2'd2;
`endif
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   logic [1:0] state;
   logic [3:0] cnt;
   // Direction of the accepted request; MAR/MDR/Mem_WE are ignored once accepted.
   logic       req_we;

   // Handshake FSM; every output is a register so nothing reaches the pins combinationally.
   always_ff @(posedge Clk) begin
      if (!Reset_al) begin
         state        <= S_IDLE;
         cnt          <= 4'd0;
         req_we       <= 1'b0;
         R            <= 1'b0;
         MDR_In       <= 16'h0000;
         SRAM_ADDR    <= 20'h00000;
         Data_to_SRAM <= 16'h0000;
         SRAM_CE_N    <= 1'b1;
         SRAM_OE_N    <= 1'b1;
         SRAM_WE_N    <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (Mem_CE) begin
                  req_we       <= Mem_WE;
                  SRAM_ADDR    <= {4'h0, MAR};
                  Data_to_SRAM <= MDR;
`ifdef LC3_MEM_MMIO_EN
                  if (MAR == 16'hFFFF) begin
                     state <= S_MMIO;
                  end else
`endif
                  begin
                     // Strobes go active on the same edge that enters ACCESS.
                     state     <= S_ACCESS;
                     cnt       <= WAIT_INIT;
                     SRAM_CE_N <= 1'b0;
                     SRAM_OE_N <= Mem_WE;
                     SRAM_WE_N <= ~Mem_WE;
                  end
               end
            end
            S_ACCESS: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  if (!req_we) MDR_In <= Data_from_SRAM;
                  R         <= 1'b1;
                  SRAM_CE_N <= 1'b1;
                  SRAM_OE_N <= 1'b1;
                  SRAM_WE_N <= 1'b1;
                  state     <= S_DONE;
               end
            end
`ifdef LC3_MEM_MMIO_EN
            S_MMIO: begin
               if (!req_we) MDR_In <= Data_SW;
               R     <= 1'b1;
               state <= S_DONE;
            end
`endif
            S_DONE: begin
               // Wait for the requester to drop Mem_CE before accepting anything new.
               if (!Mem_CE) begin
                  R     <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef LC3_MEM_MMIO_EN
   // Hex display register, loaded by an MMIO write from the latched write data.
   always_ff @(posedge Clk) begin
      if (!Reset_al) begin
         HEX_Out <= 16'h0000;
      end else if (state == S_MMIO && req_we) begin
         HEX_Out <= Data_to_SRAM;
      end
   end
`else
   // No MMIO: display register does not exist and switches are not read.
   assign HEX_Out = 16'h0000;
   logic unused_sw;
   assign unused_sw = ^Data_SW;
`endif

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Bench for lc3_mem_responder: timestamp-based transaction model checked every cycle plus directed literal checks.
module tb_lc3_mem_responder;
   localparam int W = 2;
`ifdef LC3_MEM_MMIO_EN
   localparam bit MMIO_EN = 1'b1;
`else
   localparam bit MMIO_EN = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        Reset_al;
   logic        Mem_CE, Mem_WE;
   logic [15:0] MAR, MDR, MDR_In, Data_to_SRAM, Data_from_SRAM, Data_SW, HEX_Out;
   logic        R, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;
   logic [19:0] SRAM_ADDR;

   always #5 Clk = ~Clk;

   lc3_mem_responder #(.WAIT_CYCLES(W)) dut (
      .Clk(Clk), .Reset_al(Reset_al), .Mem_CE(Mem_CE), .Mem_WE(Mem_WE),
      .MAR(MAR), .MDR(MDR), .MDR_In(MDR_In), .R(R), .SRAM_ADDR(SRAM_ADDR),
      .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
      .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
      .Data_SW(Data_SW), .HEX_Out(HEX_Out)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- transaction model ----------------
   // A request accepted at edge k completes at edge k+latency; strobes are active strictly between.
   int          edge_n = 0;
   int          fin_edge = 0;
   bit          mdl_ok = 1'b0;
   bit          busy = 1'b0;
   bit          m_R = 1'b0;
   bit          req_we, req_mmio, rd_act, wr_act;
   logic [15:0] m_mdr_in, m_hex, m_dto;
   logic [19:0] m_addr;

   always @(posedge Clk) begin
      edge_n <= edge_n + 1;
      if (!Reset_al) begin
         mdl_ok <= 1'b1; busy <= 1'b0; m_R <= 1'b0;
         m_mdr_in <= '0; m_hex <= '0; m_addr <= '0; m_dto <= '0;
         rd_act <= 1'b0; wr_act <= 1'b0;
      end else if (busy) begin
         if (edge_n == fin_edge) begin
            busy <= 1'b0; m_R <= 1'b1; rd_act <= 1'b0; wr_act <= 1'b0;
            if (req_mmio) begin
               if (req_we) m_hex <= m_dto; else m_mdr_in <= Data_SW;
            end else if (!req_we) begin
               m_mdr_in <= Data_from_SRAM;
            end
         end
      end else if (m_R) begin
         if (!Mem_CE) m_R <= 1'b0;
      end else if (Mem_CE) begin
         req_we   <= Mem_WE;
         req_mmio <= MMIO_EN && (MAR == 16'hFFFF);
         m_addr   <= {4'h0, MAR};
         m_dto    <= MDR;
         busy     <= 1'b1;
         fin_edge <= edge_n + ((MMIO_EN && MAR == 16'hFFFF) ? 1 : W + 1);
         rd_act   <= !(MMIO_EN && MAR == 16'hFFFF) && !Mem_WE;
         wr_act   <= !(MMIO_EN && MAR == 16'hFFFF) && Mem_WE;
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge Clk) begin
      if (mdl_ok) begin
         chk("cyc_R", {31'd0, R}, {31'd0, m_R});
         chk("cyc_MDR_In", {16'd0, MDR_In}, {16'd0, m_mdr_in});
         chk("cyc_HEX_Out", {16'd0, HEX_Out}, {16'd0, m_hex});
         chk("cyc_SRAM_ADDR", {12'd0, SRAM_ADDR}, {12'd0, m_addr});
         chk("cyc_Data_to_SRAM", {16'd0, Data_to_SRAM}, {16'd0, m_dto});
         chk("cyc_CE_N", {31'd0, SRAM_CE_N}, {31'd0, !(rd_act || wr_act)});
         chk("cyc_OE_N", {31'd0, SRAM_OE_N}, {31'd0, !rd_act});
         chk("cyc_WE_N", {31'd0, SRAM_WE_N}, {31'd0, !wr_act});
      end
   end

   // ---------------- directed stimulus ----------------
   // Issue a request and wait for R. n_r is the negedge index after E0 at which R was first seen (0 = timeout).
   task automatic req_go(input bit we, input logic [15:0] a, input logic [15:0] d,
                         output int n_r, output int n_ce, output int n_oe, output int n_we);
      @(negedge Clk);
      Mem_CE = 1'b1; Mem_WE = we; MAR = a; MDR = d;
      n_r = 0; n_ce = 0; n_oe = 0; n_we = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge Clk);
         if (i == 1) begin
            MAR = ~a; MDR = ~d; Mem_WE = !we;
         end
         if (SRAM_CE_N === 1'b0) n_ce++;
         if (SRAM_OE_N === 1'b0) n_oe++;
         if (SRAM_WE_N === 1'b0) n_we++;
         if (R === 1'b1) begin
            n_r = i;
            break;
         end
      end
   endtask

   task automatic release_ce();
      Mem_CE = 1'b0;
      @(negedge Clk);
      chk("release_R_low", {31'd0, R}, 32'd0);
   endtask

   int nr, nce, noe, nwe, cnt_r, cnt_s;

   initial begin
      Reset_al = 1'b0; Mem_CE = 1'b0; Mem_WE = 1'b0; MAR = '0; MDR = '0;
      Data_from_SRAM = '0; Data_SW = '0;
      repeat (2) @(negedge Clk);
      chk("rst_R", {31'd0, R}, 32'd0);
      chk("rst_MDR_In", {16'd0, MDR_In}, 32'd0);
      chk("rst_HEX", {16'd0, HEX_Out}, 32'd0);
      chk("rst_strobes", {29'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 32'd7);
      Reset_al = 1'b1;

      // SRAM read
      Data_from_SRAM = 16'h1234;
      req_go(1'b0, 16'h3000, 16'h0000, nr, nce, noe, nwe);
      chk("rd_latency", nr, 4);
      chk("rd_ce_cycles", nce, 3);
      chk("rd_oe_cycles", noe, 3);
      chk("rd_we_cycles", nwe, 0);
      chk("rd_MDR_In", {16'd0, MDR_In}, 32'h1234);
      chk("rd_SRAM_ADDR", {12'd0, SRAM_ADDR}, 32'h03000);
      release_ce();
      Data_from_SRAM = 16'hDEAD;

      // SRAM write
      req_go(1'b1, 16'h0005, 16'hBEEF, nr, nce, noe, nwe);
      chk("wr_latency", nr, 4);
      chk("wr_we_cycles", nwe, 3);
      chk("wr_oe_cycles", noe, 0);
      chk("wr_Data_to_SRAM", {16'd0, Data_to_SRAM}, 32'hBEEF);
      chk("wr_MDR_In_kept", {16'd0, MDR_In}, 32'h1234);
      release_ce();

      // Address 0xFFFF
      Data_SW = 16'h0F0F;
      Data_from_SRAM = 16'h5A5A;
      req_go(1'b1, 16'hFFFF, 16'h00A5, nr, nce, noe, nwe);
      if (MMIO_EN) begin
         chk("mmio_wr_latency", nr, 2);
         chk("mmio_wr_strobes", nce + noe + nwe, 0);
         chk("mmio_wr_HEX", {16'd0, HEX_Out}, 32'h00A5);
      end else begin
         chk("ffff_wr_latency", nr, 4);
         chk("ffff_wr_we_cycles", nwe, 3);
         chk("ffff_wr_HEX", {16'd0, HEX_Out}, 32'h0000);
      end
      release_ce();
      req_go(1'b0, 16'hFFFF, 16'h0000, nr, nce, noe, nwe);
      if (MMIO_EN) begin
         chk("mmio_rd_MDR_In", {16'd0, MDR_In}, 32'h0F0F);
         chk("mmio_rd_strobes", nce, 0);
      end else begin
         chk("ffff_rd_MDR_In", {16'd0, MDR_In}, 32'h5A5A);
         chk("ffff_rd_oe_cycles", noe, 3);
      end
      release_ce();

      // Held request: Mem_CE stays high 5 cycles past R
      Data_from_SRAM = 16'h1111;
      req_go(1'b0, 16'h0042, 16'h0000, nr, nce, noe, nwe);
      cnt_r = 0; cnt_s = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         if (R === 1'b1) cnt_r++;
         if (SRAM_CE_N === 1'b0) cnt_s++;
      end
      chk("held_R_high", cnt_r, 5);
      chk("held_no_new_access", cnt_s, 0);
      chk("held_MDR_In", {16'd0, MDR_In}, 32'h1111);
      release_ce();

      // Early drop of Mem_CE right after the request edge
      Data_from_SRAM = 16'h2222;
      @(negedge Clk);
      Mem_CE = 1'b1; Mem_WE = 1'b0; MAR = 16'h0100;
      @(negedge Clk);
      Mem_CE = 1'b0;
      cnt_r = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         if (R === 1'b1) cnt_r++;
      end
      chk("drop_R_pulse", cnt_r, 1);
      chk("drop_MDR_In", {16'd0, MDR_In}, 32'h2222);

      // Reset during ACCESS
      @(negedge Clk);
      Mem_CE = 1'b1; Mem_WE = 1'b0; MAR = 16'h0200;
      @(negedge Clk);
      Reset_al = 1'b0; Mem_CE = 1'b0;
      @(negedge Clk);
      chk("rstmid_R", {31'd0, R}, 32'd0);
      chk("rstmid_strobes", {29'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 32'd7);
      chk("rstmid_ADDR", {12'd0, SRAM_ADDR}, 32'd0);
      Reset_al = 1'b1;
      Data_from_SRAM = 16'h3333;
      req_go(1'b0, 16'h0300, 16'h0000, nr, nce, noe, nwe);
      chk("post_rst_latency", nr, 4);
      chk("post_rst_MDR_In", {16'd0, MDR_In}, 32'h3333);
      release_ce();

      repeat (2) @(negedge Clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
